regfile_sb: RTL and testbench

- Parametrised successor to the single-cycle CPU register file.
- Adds width/depth parameters, byte-enabled writes, write-to-read bypass, a per-register pending scoreboard for multi-cycle producers (loads, mul/div), and a sequential clear engine.
- Sits in the decode stage; the hazard unit consumes the Busy outputs to stall.

---
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Decode-stage register file: byte-enabled writes, write-to-read bypass,
// per-register pending scoreboard and a sequential clear engine.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RegWre,
    input  logic                WrInhibit,
    input  logic [AW-1:0]       WriteReg,
    input  logic [XLEN-1:0]     WriteData,
    input  logic [XLEN/8-1:0]   WriteBE,
    input  logic [AW-1:0]       ReadReg1,
    input  logic [AW-1:0]       ReadReg2,
    output logic [XLEN-1:0]     ReadData1,
    output logic [XLEN-1:0]     ReadData2,
    output logic                Busy1,
    output logic                Busy2,
    input  logic                SbSet,
    input  logic [AW-1:0]       SbSetReg,
    input  logic                ClrReq,
    output logic                ClrBusy
);
    localparam int NB = XLEN / 8;
    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    logic                       state;
    logic [AW-1:0]              clrCnt;
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           pending;
    logic                       idle, commit, sbSetOk, bypass1, bypass2;
    logic [XLEN-1:0]            mergeData;

    assign idle    = (state == IDLE);
    assign commit  = RegWre & ~WrInhibit & (WriteReg != '0) & idle;
    assign sbSetOk = SbSet & (SbSetReg != '0) & idle;

    // Value reg[WriteReg] will hold after this edge; also the bypass source.
    for (genvar b = 0; b < NB; b++) begin : gMerge
        assign mergeData[8*b +: 8] = WriteBE[b] ? WriteData[8*b +: 8]
                                                : regs[WriteReg][8*b +: 8];
    end

    assign bypass1 = (BYPASS != 0) & commit & (ReadReg1 == WriteReg);
    assign bypass2 = (BYPASS != 0) & commit & (ReadReg2 == WriteReg);

    assign ReadData1 = (ReadReg1 == '0) ? '0 : bypass1 ? mergeData : regs[ReadReg1];
    assign ReadData2 = (ReadReg2 == '0) ? '0 : bypass2 ? mergeData : regs[ReadReg2];
    assign Busy1     = (ReadReg1 != '0) & pending[ReadReg1] & ~bypass1;
    assign Busy2     = (ReadReg2 != '0) & pending[ReadReg2] & ~bypass2;
    assign ClrBusy   = (state == CLEAR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            clrCnt  <= '0;
            regs    <= '0;
            pending <= '0;
        end else if (state == IDLE) begin
            if (commit) begin
                regs[WriteReg]    <= mergeData;
                pending[WriteReg] <= 1'b0;
            end
            // Later assignment lets a same-register set beat the commit clear.
            if (sbSetOk) pending[SbSetReg] <= 1'b1;
            if (ClrReq) begin
                state   <= CLEAR;
                clrCnt  <= AW'(1);
                pending <= '0;
            end
        end else begin
            regs[clrCnt] <= '0;
            if (clrCnt == AW'(NREGS - 1)) begin
                state  <= IDLE;
                clrCnt <= '0;
            end else begin
                clrCnt <= clrCnt + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb; two instances (BYPASS=1/0)
// share stimulus and are checked every cycle against a behavioural model.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic CLK = 1'b0, RST_N = 1'b1;
    logic RegWre = 0, WrInhibit = 0, SbSet = 0, ClrReq = 0;
    logic [AW-1:0] WriteReg = '0, ReadReg1 = '0, ReadReg2 = '0, SbSetReg = '0;
    logic [XLEN-1:0] WriteData = '0;
    logic [3:0] WriteBE = '0;
    logic [XLEN-1:0] rd1A, rd2A, rd1B, rd2B;
    logic busy1A, busy2A, clrBusyA, busy1B, busy2B, clrBusyB;

    int nVec = 0, nErr = 0;
    bit chkOn = 0;

    always #5 CLK = ~CLK;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dutA (
        .CLK(CLK), .RST_N(RST_N), .RegWre(RegWre), .WrInhibit(WrInhibit),
        .WriteReg(WriteReg), .WriteData(WriteData), .WriteBE(WriteBE),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1A), .ReadData2(rd2A),
        .Busy1(busy1A), .Busy2(busy2A), .SbSet(SbSet), .SbSetReg(SbSetReg),
        .ClrReq(ClrReq), .ClrBusy(clrBusyA));

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dutB (
        .CLK(CLK), .RST_N(RST_N), .RegWre(RegWre), .WrInhibit(WrInhibit),
        .WriteReg(WriteReg), .WriteData(WriteData), .WriteBE(WriteBE),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1B), .ReadData2(rd2B),
        .Busy1(busy1B), .Busy2(busy2B), .SbSet(SbSet), .SbSetReg(SbSetReg),
        .ClrReq(ClrReq), .ClrBusy(clrBusyB));

    // Behavioural model: plain arrays plus a countdown of registers left to clear.
    logic [XLEN-1:0] mRegs [NREGS];
    bit              mPend [NREGS];
    int              remain = 0;

    initial for (int i = 0; i < NREGS; i++) begin mRegs[i] = '0; mPend[i] = 0; end

    function automatic bit mCommit();
        return RegWre && !WrInhibit && WriteReg != 0 && remain == 0;
    endfunction

    function automatic logic [XLEN-1:0] expRd(input logic [AW-1:0] rr, input bit byp);
        logic [XLEN-1:0] v;
        if (rr == 0) return '0;
        v = mRegs[rr];
        if (byp && mCommit() && rr == WriteReg)
            for (int k = 0; k < 4; k++) if (WriteBE[k]) v[8*k +: 8] = WriteData[8*k +: 8];
        return v;
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] rr, input bit byp);
        return rr != 0 && mPend[rr] && !(byp && mCommit() && rr == WriteReg);
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin mRegs[i] = '0; mPend[i] = 0; end
            remain = 0;
        end else if (remain > 0) begin
            mRegs[NREGS - remain] = '0;
            remain = remain - 1;
        end else begin
            if (mCommit()) begin
                mRegs[WriteReg] = expRd(WriteReg, 1);
                mPend[WriteReg] = 0;
            end
            if (SbSet && SbSetReg != 0) mPend[SbSetReg] = 1;
            if (ClrReq) begin
                remain = NREGS - 1;
                for (int i = 0; i < NREGS; i++) mPend[i] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) if (chkOn) begin
        chk("rd1_byp",   rd1A, expRd(ReadReg1, 1));
        chk("rd2_byp",   rd2A, expRd(ReadReg2, 1));
        chk("busy1_byp", 32'(busy1A), 32'(expBusy(ReadReg1, 1)));
        chk("busy2_byp", 32'(busy2A), 32'(expBusy(ReadReg2, 1)));
        chk("clr_byp",   32'(clrBusyA), 32'(remain > 0));
        chk("rd1_nobyp", rd1B, expRd(ReadReg1, 0));
        chk("rd2_nobyp", rd2B, expRd(ReadReg2, 0));
        chk("busy1_nobyp", 32'(busy1B), 32'(expBusy(ReadReg1, 0)));
        chk("busy2_nobyp", 32'(busy2B), 32'(expBusy(ReadReg2, 0)));
        chk("clr_nobyp", 32'(clrBusyB), 32'(remain > 0));
    end

    task automatic tick(); @(posedge CLK); #1; endtask
    task automatic mid();  @(negedge CLK); #1; endtask

    task automatic wr(input int r, input logic [31:0] d, input logic [3:0] be);
        RegWre = 1; WriteReg = AW'(r); WriteData = d; WriteBE = be;
    endtask

    task automatic quiet();
        RegWre = 0; WrInhibit = 0; SbSet = 0; ClrReq = 0;
    endtask

    initial begin
        int cnt;
        #1 RST_N = 0;
        chkOn = 1;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1;

        // Reset state
        ReadReg1 = 5; mid();
        chk("reset_rd1", rd1A, 32'h0);
        chk("reset_clrbusy", 32'(clrBusyA), 32'h0);

        // Full write with bypass, then array read
        tick(); wr(5, 32'hDEADBEEF, 4'hF); ReadReg1 = 5; ReadReg2 = 0;
        mid();
        chk("x5_bypass", rd1A, 32'hDEADBEEF);
        chk("x5_nobypass_old", rd1B, 32'h0);
        tick(); quiet(); mid();
        chk("x5_array", rd1A, 32'hDEADBEEF);
        chk("x5_array_nobyp", rd1B, 32'hDEADBEEF);
        chk("rd2_zero", rd2A, 32'h0);

        // Byte-enable merge, then inhibited write
        tick(); wr(7, 32'h11223344, 4'hF);
        tick(); wr(7, 32'hAABBCCDD, 4'b0101);
        tick(); quiet(); ReadReg1 = 7; mid();
        chk("x7_merge", rd1A, 32'h11BB33DD);
        chk("x7_model", mRegs[7], 32'h11BB33DD);
        tick(); wr(7, 32'h0, 4'hF); WrInhibit = 1;
        tick(); quiet(); mid();
        chk("x7_inhibit", rd1A, 32'h11BB33DD);

        // Register 0 ignores writes and scoreboard sets
        tick(); wr(0, 32'hFFFFFFFF, 4'hF); SbSet = 1; SbSetReg = 0; ReadReg1 = 0;
        tick(); quiet(); mid();
        chk("x0_rd", rd1A, 32'h0);
        chk("x0_busy", 32'(busy1A), 32'h0);

        // Scoreboard set / clear / set-wins
        tick(); SbSet = 1; SbSetReg = 9; ReadReg1 = 9;
        tick(); quiet(); mid();
        chk("x9_busy", 32'(busy1A), 32'h1);
        tick(); wr(9, 32'h0000_0999, 4'hF); mid();
        chk("x9_commit_byp", 32'(busy1A), 32'h0);
        chk("x9_commit_nobyp", 32'(busy1B), 32'h1);
        tick(); quiet(); mid();
        chk("x9_cleared", 32'(busy1A), 32'h0);
        tick(); wr(9, 32'h0000_0AAA, 4'hF); SbSet = 1; SbSetReg = 9;
        tick(); quiet(); mid();
        chk("x9_setwins", 32'(busy1A), 32'h1);

        // BYPASS=0 sees old value on same-cycle write/read
        tick(); wr(4, 32'h12345678, 4'hF);
        tick(); wr(4, 32'h9ABCDEF0, 4'hF); ReadReg1 = 4; mid();
        chk("x4_nobyp_old", rd1B, 32'h12345678);
        chk("x4_byp_new", rd1A, 32'h9ABCDEF0);
        tick(); quiet();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            RegWre    = ($urandom % 4) != 0;
            WrInhibit = ($urandom % 6) == 0;
            WriteReg  = AW'($urandom);
            WriteData = $urandom;
            WriteBE   = 4'($urandom);
            ReadReg1  = ($urandom % 3 == 0) ? WriteReg : AW'($urandom);
            ReadReg2  = ($urandom % 3 == 0) ? WriteReg : AW'($urandom);
            SbSet     = ($urandom % 4) == 0;
            SbSetReg  = ($urandom % 3 == 0) ? WriteReg : AW'($urandom);
            ClrReq    = ($urandom % 60) == 0;
            tick();
        end
        quiet();
        repeat (NREGS) tick();

        // Fill with pending set, then full clear with a dropped write
        for (int r = 1; r < NREGS; r++) begin
            wr(r, $urandom | 32'h1, 4'hF); SbSet = 1; SbSetReg = AW'(r);
            tick();
        end
        quiet(); ClrReq = 1; tick(); ClrReq = 0;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            mid();
            if (!clrBusyA) break;
            cnt++;
            if (cnt == 5) begin wr(3, 32'hFFFF, 4'hF); ReadReg1 = 3; end
            else RegWre = 0;
            tick();
        end
        chk("clr_cycles", 32'(cnt), 32'd31);
        quiet();
        for (int r = 1; r < NREGS; r++) begin
            ReadReg1 = AW'(r); ReadReg2 = AW'(r); mid();
            chk("post_clr_rd", rd1A, 32'h0);
            chk("post_clr_busy", 32'(busy1A), 32'h0);
            tick();
        end

        // Async reset aborts a clear in progress
        wr(31, 32'hCAFEF00D, 4'hF); tick(); quiet();
        ReadReg1 = 31; ClrReq = 1; tick(); ClrReq = 0;
        repeat (9) tick();
        mid();
        chk("pre_abort_busy", 32'(clrBusyA), 32'h1);
        chk("pre_abort_x31", rd1A, 32'hCAFEF00D);
        @(posedge CLK); #2 RST_N = 0; #1;
        chk("abort_clrbusy", 32'(clrBusyA), 32'h0);
        chk("abort_clrbusy_b", 32'(clrBusyB), 32'h0);
        chk("abort_x31", rd1A, 32'h0);
        tick(); RST_N = 1; tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
